instr_encoder: RTL
==================

# instr_encoder

Pipelined RV32I instruction encoder: accepts a symbolic operation (op code, register indices, 32-bit immediate) over a valid/ready handshake and emits the packed 32-bit instruction word the control unit decodes. It is the producer side of the instruction format, used by the self-test program generator and boot loader to build instruction memory images in hardware. It is a two-stage pipeline with full backpressure, optional immediate-range checking and emit/error counters.

## Interface
- CNT_W, 16, width of emitted-instruction and error counters
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept this cycle
- in_op  input  5  enc_op_t operation (see Operation)
- in_rd / in_rs1 / in_rs2  input  5 each  register indices
- in_imm  input  32  signed byte-offset/immediate (U-type: full value, low 12 bits expected zero)
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer takes word this cycle
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate out of range for this word
- emit_cnt  output  CNT_W  words handed off (wraps)
- err_cnt  output  CNT_W  words handed off with out_err=1 (saturates)

## Operation
- Ops: ADD SUB SLL XOR SRL OR AND (R, opcode 0110011); ADDI SLLI XORI SRLI ORI ANDI (I-ALU, 0010011); LW LBU (I, 0000011); SW SB (S, 0100011); BEQ BNE (B, 1100011); LUI (0110111); AUIPC (0010111); JAL (1101111); JALR (1100111). Encodings 0–22; 23–31 illegal.
- funct3: ADD/SUB/ADDI/JALR/BEQ/SB 000; SLL/SLLI/BNE 001; LW/SW 010; XOR/XORI/LBU 100; SRL/SRLI 101; OR/ORI 110; AND/ANDI 111. funct7 = 0100000 for SUB only, else 0.
- Stage 1 (S1): register operands, decode op to opcode/funct3/funct7/format.
- Stage 2 (S2): assemble word per format from RISC-V spec bit placement (B and J drop imm[0]; U uses imm[31:12]; SLLI/SRLI use imm[4:0] with funct7 in [31:25]); register out_instr, out_err.
- Illegal op: out_instr = 32'h00000013 (NOP), out_err = 1 regardless of macro.
- Counters update on output handshake (out_valid && out_ready) only.

## Timing
- Reset: in_ready=1 after reset, out_valid=0, out_instr=0, out_err=0, emit_cnt=0, err_cnt=0; in-flight words discarded.
- Accept when in_valid && in_ready. Accepted at edge N → out_valid high after edge N+1 (latency 2 edges).
- Advance rule: stage loads when empty or its contents leave this cycle; in_ready = !s1_valid || (s1 moves to S2). No combinational path from out_ready to out_instr; in_ready may depend combinationally on out_ready.
- Sustained throughput 1 word/cycle with out_ready=1; out_ready=0 holds out_instr/out_err stable, pipeline fills (2 words), then in_ready=0.
- Simultaneous accept and emit in same cycle: both occur, no bubble.
- emit_cnt wraps 2^CNT_W−1→0; err_cnt holds at 2^CNT_W−1.
- rst mid-stream overrides all handshakes that cycle.

## Configuration
- ENC_IMM_CHECK_EN defined: range check in S1 — I/S signed 12-bit; B signed 13-bit, even; J signed 21-bit, even; U low 12 bits zero; shift imm 0..31. Failure → out_instr = NOP, out_err=1.
- Undefined: no checks, immediates silently truncated to field; out_err only for illegal op.

## Structure
- enc_pkg: enc_op_t enum, fmt_t enum (R, I, S, B, U, J), opcode localparams shared with the control unit's opcode values, NOP constant.
- Sub-module instr_pack: combinational format-driven bit assembly (fmt, opcode, funct3, funct7, rd, rs1, rs2, imm → word), instanced in S2 and reusable by a future assembler testbench.

## Test plan
- ADD x1,x2,x3 → 0x003100B3; SUB x1,x2,x3 → 0x403100B3; out_valid 2 edges after accept, out_err=0.
- ADDI x5,x0,-1 → 0xFFF00293; LUI x10,0x12345000 → 0x12345537; BEQ x1,x2,+8 → 0x00208463; JAL x0,-4 → 0xFFDFF06F.
- Back-to-back 8 ops with out_ready=1 → 8 words on consecutive cycles, emit_cnt=8.
- out_ready=0 for 5 cycles during stream → out_instr stable, in_ready=0 after 2 accepts, no loss/duplication on release.
- With ENC_IMM_CHECK_EN: ADDI imm=2048 → 0x00000013, out_err=1, err_cnt=1; BEQ imm=3 → NOP, err. Without macro: ADDI imm=2048 → 0x80000013, out_err=0.
- in_op=25 → NOP, out_err=1; rst asserted with 2 words in flight → out_valid=0 next cycle, counters 0.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg -- shared definitions for the RV32I instruction encoder.
//   enc_op_t    : symbolic operation codes accepted by instr_encoder (0..22, rest illegal)
//   fmt_t       : RISC-V instruction formats
//   OPC_*       : major opcodes, identical to the control unit's decode values
//   NOP_INSTR   : canonical NOP (addi x0,x0,0), emitted for rejected requests
//   decode_op   : op -> format/opcode/funct3/funct7/shift flag/legal flag
//   imm_in_range: immediate range check used when ENC_IMM_CHECK_EN is defined
package enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLL  = 5'd2,  OP_XOR  = 5'd3,
    OP_SRL   = 5'd4,  OP_OR    = 5'd5,  OP_AND  = 5'd6,  OP_ADDI = 5'd7,
    OP_SLLI  = 5'd8,  OP_XORI  = 5'd9,  OP_SRLI = 5'd10, OP_ORI  = 5'd11,
    OP_ANDI  = 5'd12, OP_LW    = 5'd13, OP_LBU  = 5'd14, OP_SW   = 5'd15,
    OP_SB    = 5'd16, OP_BEQ   = 5'd17, OP_BNE  = 5'd18, OP_LUI  = 5'd19,
    OP_AUIPC = 5'd20, OP_JAL   = 5'd21, OP_JALR = 5'd22
  } enc_op_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic       legal;
    logic       shift;   // SLLI/SRLI: I-format with shamt + funct7 in the immediate field
    fmt_t       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [4:0] op);
    op_dec_t d;
    d.legal  = 1'b1;
    d.shift  = (op == OP_SLLI) || (op == OP_SRLI);
    d.fmt    = FMT_I;
    d.opcode = OPC_OP_IMM;
    d.funct3 = 3'b000;
    d.funct7 = (op == OP_SUB) ? 7'b0100000 : 7'b0000000;
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_OR, OP_AND: begin
        d.fmt = FMT_R; d.opcode = OPC_OP;
      end
      OP_ADDI, OP_SLLI, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI: begin
        d.fmt = FMT_I; d.opcode = OPC_OP_IMM;
      end
      OP_LW, OP_LBU:   begin d.fmt = FMT_I; d.opcode = OPC_LOAD;   end
      OP_SW, OP_SB:    begin d.fmt = FMT_S; d.opcode = OPC_STORE;  end
      OP_BEQ, OP_BNE:  begin d.fmt = FMT_B; d.opcode = OPC_BRANCH; end
      OP_LUI:          begin d.fmt = FMT_U; d.opcode = OPC_LUI;    end
      OP_AUIPC:        begin d.fmt = FMT_U; d.opcode = OPC_AUIPC;  end
      OP_JAL:          begin d.fmt = FMT_J; d.opcode = OPC_JAL;    end
      OP_JALR:         begin d.fmt = FMT_I; d.opcode = OPC_JALR;   end
      default:         d.legal = 1'b0;
    endcase
    case (op)
      OP_SLL, OP_SLLI, OP_BNE:  d.funct3 = 3'b001;
      OP_LW, OP_SW:             d.funct3 = 3'b010;
      OP_XOR, OP_XORI, OP_LBU:  d.funct3 = 3'b100;
      OP_SRL, OP_SRLI:          d.funct3 = 3'b101;
      OP_OR, OP_ORI:            d.funct3 = 3'b110;
      OP_AND, OP_ANDI:          d.funct3 = 3'b111;
      default:                  d.funct3 = 3'b000;
    endcase
    return d;
  endfunction

  // A value fits a signed N-bit field when every bit from N-1 upward is equal.
  function automatic logic imm_in_range(input fmt_t fmt, input logic shift,
                                        input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    if (shift) begin
      ok = (imm[31:5] == 27'd0);
    end else begin
      case (fmt)
        FMT_I, FMT_S: ok = (&imm[31:11]) || !(|imm[31:11]);
        FMT_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
        FMT_J:        ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
        FMT_U:        ok = (imm[11:0] == 12'd0);
        default:      ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack -- combinational RV32I bit assembly.
//   fmt, opcode, funct3, funct7 : decoded fields
//   rd, rs1, rs2                : register indices
//   imm                         : immediate (B/J drop imm[0], U uses imm[31:12])
//   word                        : packed 32-bit instruction (NOP for unknown format)
module instr_pack
  import enc_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP_INSTR;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = NOP_INSTR;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- two-stage pipelined RV32I instruction encoder.
//   S1 registers operands and the decoded op; S2 packs the word into the output register.
//   in_valid/in_ready, in_op/in_rd/in_rs1/in_rs2/in_imm : request side
//   out_valid/out_ready, out_instr, out_err            : word side (registered)
//   emit_cnt (wraps), err_cnt (saturates)               : count output handshakes
// Build option: define ENC_IMM_CHECK_EN to reject out-of-range immediates
// (word becomes NOP with out_err=1); otherwise immediates are truncated to their field.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // S1 state
  logic        s1_valid_reg;
  logic        s1_err_reg;
  logic        s1_shift_reg;
  fmt_t        s1_fmt_reg;
  logic [6:0]  s1_opcode_reg;
  logic [2:0]  s1_funct3_reg;
  logic [6:0]  s1_funct7_reg;
  logic [4:0]  s1_rd_reg;
  logic [4:0]  s1_rs1_reg;
  logic [4:0]  s1_rs2_reg;
  logic [31:0] s1_imm_reg;

  // S2 / output state
  logic             out_valid_reg;
  logic [31:0]      out_instr_reg;
  logic             out_err_reg;
  logic [CNT_W-1:0] emit_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  op_dec_t     in_dec;
  logic        in_err;
  logic        s1_load;
  logic        s2_load;
  logic        out_fire;
  logic [31:0] pack_imm;
  logic [31:0] pack_word;

  always_comb begin
    in_dec = decode_op(in_op);
`ifdef ENC_IMM_CHECK_EN
    in_err = !in_dec.legal || !imm_in_range(in_dec.fmt, in_dec.shift, in_imm);
`else
    in_err = !in_dec.legal;
`endif
  end

  // S1 hands its word to the output register when that register is empty or
  // being drained this cycle; in_ready follows so the pipeline never bubbles.
  assign out_fire = out_valid_reg && out_ready;
  assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Shifts reuse the I layout: shamt in imm[4:0], funct7 in imm[11:5].
  assign pack_imm = s1_shift_reg ? {20'd0, s1_funct7_reg, s1_imm_reg[4:0]} : s1_imm_reg;

  instr_pack u_pack (
    .fmt    (s1_fmt_reg),
    .opcode (s1_opcode_reg),
    .funct3 (s1_funct3_reg),
    .funct7 (s1_funct7_reg),
    .rd     (s1_rd_reg),
    .rs1    (s1_rs1_reg),
    .rs2    (s1_rs2_reg),
    .imm    (pack_imm),
    .word   (pack_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_err_reg    <= 1'b0;
      s1_shift_reg  <= 1'b0;
      s1_fmt_reg    <= FMT_I;
      s1_opcode_reg <= 7'd0;
      s1_funct3_reg <= 3'd0;
      s1_funct7_reg <= 7'd0;
      s1_rd_reg     <= 5'd0;
      s1_rs1_reg    <= 5'd0;
      s1_rs2_reg    <= 5'd0;
      s1_imm_reg    <= 32'd0;
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'd0;
      out_err_reg   <= 1'b0;
      emit_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg  <= 1'b1;
        s1_err_reg    <= in_err;
        s1_shift_reg  <= in_dec.shift;
        s1_fmt_reg    <= in_dec.fmt;
        s1_opcode_reg <= in_dec.opcode;
        s1_funct3_reg <= in_dec.funct3;
        s1_funct7_reg <= in_dec.funct7;
        s1_rd_reg     <= in_rd;
        s1_rs1_reg    <= in_rs1;
        s1_rs2_reg    <= in_rs2;
        s1_imm_reg    <= in_imm;
      end else if (s2_load) begin
        s1_valid_reg  <= 1'b0;
      end

      if (s2_load) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= s1_err_reg ? NOP_INSTR : pack_word;
        out_err_reg   <= s1_err_reg;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end

      if (out_fire) begin
        emit_cnt_reg <= emit_cnt_reg + CNT_ONE;
        if (out_err_reg && (err_cnt_reg != CNT_MAX)) begin
          err_cnt_reg <= err_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;
  assign emit_cnt  = emit_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule
